// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the RV32I decode stage.
//   - instruction-class (mode) constants
//   - major opcode constants and R-type funct7 values
//   - dec_rec_t: XLEN-independent part of a decoded record
//   - opcode_mode(): opcode -> mode classification
package decode_pkg;

    localparam logic [3:0] MODE_NULL    = 4'd0;
    localparam logic [3:0] MODE_R       = 4'd1;
    localparam logic [3:0] MODE_I       = 4'd2;
    localparam logic [3:0] MODE_LOAD    = 4'd3;
    localparam logic [3:0] MODE_STORE   = 4'd4;
    localparam logic [3:0] MODE_BRANCH  = 4'd5;
    localparam logic [3:0] MODE_JAL     = 4'd6;
    localparam logic [3:0] MODE_LUI     = 4'd7;
    localparam logic [3:0] MODE_AUIPC   = 4'd8;
    localparam logic [3:0] MODE_ILLEGAL = 4'd9;
    localparam logic [3:0] MODE_JALR    = 4'd10;
    localparam logic [3:0] MODE_SYSTEM  = 4'd11;

    localparam logic [6:0] OP_NULL   = 7'h00;
    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    // Immediate and PC are kept outside the record because their widths
    // are parameters of the stage.
    typedef struct packed {
        logic [3:0] mode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       illegal;
    } dec_rec_t;

    function automatic logic [3:0] opcode_mode(input logic [6:0] opcode);
        case (opcode)
            OP_NULL:   return MODE_NULL;
            OP_R:      return MODE_R;
            OP_I:      return MODE_I;
            OP_LOAD:   return MODE_LOAD;
            OP_STORE:  return MODE_STORE;
            OP_BRANCH: return MODE_BRANCH;
            OP_JAL:    return MODE_JAL;
            OP_LUI:    return MODE_LUI;
            OP_AUIPC:  return MODE_AUIPC;
            OP_JALR:   return MODE_JALR;
            OP_SYSTEM: return MODE_SYSTEM;
            default:   return MODE_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate builder.
//   instr [31:7] : instruction bits above the opcode
//   mode  [3:0]  : instruction class from decode_pkg
//   imm   [XLEN] : immediate, sign-extended to XLEN (system: zero-extended);
//                  0 for R-type, null and unknown classes
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic        [31:7]     instr,
    input  logic        [3:0]      mode,
    output logic signed [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (mode)
            MODE_I, MODE_LOAD, MODE_JALR:
                imm = XLEN'($signed(instr[31:20]));
            MODE_STORE:
                imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            MODE_BRANCH:
                imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            MODE_JAL:
                imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            MODE_LUI, MODE_AUIPC:
                imm = XLEN'($signed({instr[31:12], 12'b0}));
            // CSR address / zimm field: unsigned.
            MODE_SYSTEM:
                imm = XLEN'(instr[31:20]);
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered RV32I decode stage with a 2-entry elastic
// buffer between fetch and register-read/execute.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   flush               : drop every buffered entry and any same-cycle push
//   in_valid/in_ready   : upstream handshake, in_instr/in_pc carried with it
//   out_valid/out_ready : downstream handshake for the decoded record
//   out_mode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_imm,
//   out_pc, out_illegal : decoded record (all zero while out_valid is low)
//   ill_count           : saturating count of accepted illegal instructions
// Build option: define DEC_RV32M_EN to accept R-type funct7 0x01 (M extension)
// and add the out_muldiv output.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,
    parameter int ILL_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [PC_W-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           out_mode,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [2:0]           out_funct3,
    output logic [6:0]           out_funct7,
    output logic [XLEN-1:0]      out_imm,
    output logic [PC_W-1:0]      out_pc,
    output logic                 out_illegal,
    output logic [ILL_CNT_W-1:0] ill_count
`ifdef DEC_RV32M_EN
    ,
    output logic                 out_muldiv
`endif
);

    logic [3:0]             dec_mode;
    logic                   f7_legal;
    dec_rec_t               dec_rec;
    logic signed [XLEN-1:0] raw_imm;
    logic [XLEN-1:0]        dec_imm;

    dec_rec_t               rec_q [2];
    logic [XLEN-1:0]        imm_q [2];
    logic [PC_W-1:0]        pc_q  [2];
    dec_rec_t               head_rec;

    logic [1:0]             count_q, count_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [ILL_CNT_W-1:0]   ill_count_q, ill_count_d;
    logic                   push, pop;

    // Decode on the input side so a buffered entry is already complete.
    assign dec_mode = opcode_mode(in_instr[6:0]);

`ifdef DEC_RV32M_EN
    logic dec_muldiv;
    logic muldiv_q [2];

    assign f7_legal   = (in_instr[31:25] == F7_BASE) || (in_instr[31:25] == F7_ALT) ||
                        (in_instr[31:25] == F7_MULDIV);
    assign dec_muldiv = (dec_mode == MODE_R) && (in_instr[31:25] == F7_MULDIV);
`else
    assign f7_legal   = (in_instr[31:25] == F7_BASE) || (in_instr[31:25] == F7_ALT);
`endif

    always_comb begin
        dec_rec         = '0;
        dec_rec.mode    = dec_mode;
        dec_rec.rd      = in_instr[11:7];
        dec_rec.rs1     = in_instr[19:15];
        dec_rec.rs2     = in_instr[24:20];
        dec_rec.funct3  = in_instr[14:12];
        dec_rec.funct7  = in_instr[31:25];
        // Non-zero opcodes without the 2'b11 suffix are compressed/unknown.
        dec_rec.illegal = (dec_mode == MODE_ILLEGAL) ||
                          ((in_instr[1:0] != 2'b11) && (in_instr[6:0] != OP_NULL)) ||
                          ((dec_mode == MODE_R) && !f7_legal);
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr[31:7]),
        .mode  (dec_mode),
        .imm   (raw_imm)
    );

    assign dec_imm = dec_rec.illegal ? '0 : raw_imm;

    // Handshake flags come only from registered occupancy.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ill_count_d = ill_count_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
        if (push && dec_rec.illegal && (ill_count_q != '1)) begin
            ill_count_d = ill_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            ill_count_q <= '0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ill_count_q <= ill_count_d;
        end
    end

    // Entry storage needs no reset: outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            rec_q[wr_ptr_q] <= dec_rec;
            imm_q[wr_ptr_q] <= dec_imm;
            pc_q[wr_ptr_q]  <= in_pc;
`ifdef DEC_RV32M_EN
            muldiv_q[wr_ptr_q] <= dec_muldiv;
`endif
        end
    end

    assign head_rec    = out_valid ? rec_q[rd_ptr_q] : '0;
    assign out_mode    = head_rec.mode;
    assign out_rd      = head_rec.rd;
    assign out_rs1     = head_rec.rs1;
    assign out_rs2     = head_rec.rs2;
    assign out_funct3  = head_rec.funct3;
    assign out_funct7  = head_rec.funct7;
    assign out_illegal = head_rec.illegal;
    assign out_imm     = out_valid ? imm_q[rd_ptr_q] : '0;
    assign out_pc      = out_valid ? pc_q[rd_ptr_q]  : '0;
    assign ill_count   = ill_count_q;
`ifdef DEC_RV32M_EN
    assign out_muldiv  = out_valid && muldiv_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;

    localparam int XLEN      = 32;
    localparam int PC_W      = 32;
    localparam int ILL_CNT_W = 2;
`ifdef DEC_RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]          in_instr;
    logic [PC_W-1:0]      in_pc;
    logic [3:0]           out_mode;
    logic [4:0]           out_rd, out_rs1, out_rs2;
    logic [2:0]           out_funct3;
    logic [6:0]           out_funct7;
    logic [XLEN-1:0]      out_imm;
    logic [PC_W-1:0]      out_pc;
    logic                 out_illegal;
    logic [ILL_CNT_W-1:0] ill_count;
`ifdef DEC_RV32M_EN
    logic                 out_muldiv;
`endif

    always #5 clk = ~clk;

    instr_decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .ILL_CNT_W(ILL_CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mode(out_mode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_pc(out_pc), .out_illegal(out_illegal), .ill_count(ill_count)
`ifdef DEC_RV32M_EN
        , .out_muldiv(out_muldiv)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  mode;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ill;
        logic        md;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          exp_ill = 0;
    logic [31:0] next_pc = 32'h0000_1000;

    function automatic exp_t mk(input logic [31:0] instr, input logic [3:0] mode,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm,
                                input logic ill, input logic md);
        exp_t e;
        e.instr = instr; e.mode = mode; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.f3 = f3; e.f7 = f7; e.imm = imm; e.ill = ill; e.md = md; e.pc = '0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Drive one instruction; the expectation is queued once acceptance is certain.
    task automatic send(input exp_t e);
        int n;
        @(posedge clk); #1;
        e.pc     = next_pc;
        in_valid = 1'b1;
        in_instr = e.instr;
        in_pc    = e.pc;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: instr %h not accepted, in_ready=%b required 1", e.instr, in_ready);
        end else begin
            exp_q.push_back(e);
            next_pc = next_pc + 32'd4;
            if (e.ill && exp_ill != 3) exp_ill++;
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: pops the oldest expectation on every downstream transfer.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got mode=%0d imm=%h pc=%h, required no entry",
                         out_mode, out_imm, out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_mode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
                     out_imm, out_illegal, out_pc} !==
                    {mon_e.mode, mon_e.rd, mon_e.rs1, mon_e.rs2, mon_e.f3, mon_e.f7,
                     mon_e.imm, mon_e.ill, mon_e.pc}
`ifdef DEC_RV32M_EN
                    || out_muldiv !== mon_e.md
`endif
                    ) begin
                    errors++;
                    $display("FAIL decode_%h: got mode=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h ill=%b pc=%h, required mode=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h ill=%b pc=%h",
                             mon_e.instr, out_mode, out_rd, out_rs1, out_rs2, out_funct3,
                             out_funct7, out_imm, out_illegal, out_pc,
                             mon_e.mode, mon_e.rd, mon_e.rs1, mon_e.rs2, mon_e.f3,
                             mon_e.f7, mon_e.imm, mon_e.ill, mon_e.pc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_ill_count", 32'(ill_count), 32'd0);
        chk("rst_out_mode", 32'(out_mode), 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;

        // Latency: entry visible one cycle after acceptance.
        send(mk(32'h00500093, 4'd2, 5'd1, 5'd0, 5'd5, 3'd0, 7'h00, 32'd5, 1'b0, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("latency_out_valid", 32'(out_valid), 32'd1);

        send(mk(32'h00112623, 4'd4, 5'd12, 5'd2, 5'd1, 3'd2, 7'h00, 32'd12, 1'b0, 1'b0));
        send(mk(32'h008000EF, 4'd6, 5'd1, 5'd0, 5'd8, 3'd0, 7'h00, 32'd8, 1'b0, 1'b0));
        send(mk(32'hFFFFFFFF, 4'd9, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'd0, 1'b1, 1'b0));
        idle(2);
        chk("ill_count_first", 32'(ill_count), 32'd1);

        // Backpressure: two accepted, third held until a slot frees.
        out_ready = 1'b0;
        send(mk(32'h0040A183, 4'd3, 5'd3, 5'd1, 5'd4, 3'd2, 7'h00, 32'd4, 1'b0, 1'b0));
        send(mk(32'h002081B3, 4'd1, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 1'b0, 1'b0));
        @(posedge clk); #1;
        in_instr = 32'hFE000EE3;
        in_pc    = next_pc;
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_in_ready_held", 32'(in_ready), 32'd0);
            chk("bp_out_valid_held", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        send(mk(32'hFE000EE3, 4'd5, 5'd29, 5'd0, 5'd0, 3'd0, 7'h7F, 32'hFFFFFFFC, 1'b0, 1'b0));
        idle(3);

        // Flush while full, with a push offered in the same cycle.
        out_ready = 1'b0;
        send(mk(32'h123452B7, 4'd7, 5'd5, 5'd8, 5'd3, 3'd5, 7'h09, 32'h12345000, 1'b0, 1'b0));
        send(mk(32'hFFF02073, 4'd11, 5'd0, 5'd0, 5'd31, 3'd2, 7'h7F, 32'h00000FFF, 1'b0, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_instr = 32'hFFC08067;
        flush    = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_full_out_valid", 32'(out_valid), 32'd0);
        chk("flush_full_in_ready", 32'(in_ready), 32'd1);

        // Flush with room available: illegal push dropped, not counted.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h00000001;
        flush     = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_push_out_valid", 32'(out_valid), 32'd0);
        chk("flush_ill_count", 32'(ill_count), 32'd1);
        idle(2);

        send(mk(32'h402081B3, 4'd1, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 1'b0, 1'b0));
        send(mk(32'h02208033, 4'd1, 5'd0, 5'd1, 5'd2, 3'd0, 7'h01, 32'd0, !M_EN, M_EN));
        send(mk(32'h00000001, 4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 1'b1, 1'b0));
        send(mk(32'h00000000, 4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 1'b0, 1'b0));
        send(mk(32'hFFC08067, 4'd10, 5'd0, 5'd1, 5'd28, 3'd0, 7'h7F, 32'hFFFFFFFC, 1'b0, 1'b0));
        idle(3);
        chk("ill_count_mix", 32'(ill_count), 32'(exp_ill));

        // Five more illegal encodings: counter holds at all-ones.
        send(mk(32'h0000007F, 4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 1'b1, 1'b0));
        send(mk(32'h0000000B, 4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 1'b1, 1'b0));
        send(mk(32'hFFFFFFFF, 4'd9, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'd0, 1'b1, 1'b0));
        send(mk(32'h00000002, 4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 1'b1, 1'b0));
        send(mk(32'h04000033, 4'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'h02, 32'd0, 1'b1, 1'b0));
        idle(3);
        chk("ill_count_saturated", 32'(ill_count), 32'd3);

        // Reset mid-stream discards buffered entries.
        out_ready = 1'b0;
        send(mk(32'h00500093, 4'd2, 5'd1, 5'd0, 5'd5, 3'd0, 7'h00, 32'd5, 1'b0, 1'b0));
        send(mk(32'h00112623, 4'd4, 5'd12, 5'd2, 5'd1, 3'd2, 7'h00, 32'd12, 1'b0, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        exp_ill = 0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_ill_count", 32'(ill_count), 32'd0);
        chk("midrst_out_mode", 32'(out_mode), 32'd0);
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
